// File: rtl/gl_pkg.sv
// ============================================================================
//  Module      : gl_pkg
//  Description : Shared constants and types for the framebuffer write stage.
//                GL_FB_CLEAR_EN adds the CLEAR state to the state enum.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gl_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int PIXEL_W   = 18;
  localparam int FRAG_W    = 96;

  // Fragment field positions inside the 96-bit FIFO word
  localparam int Y_LSB = 80;
  localparam int Y_W   = 9;
  localparam int X_LSB = 64;
  localparam int X_W   = 10;
  localparam int R_LSB = 50;
  localparam int G_LSB = 42;
  localparam int B_LSB = 34;
  localparam int C_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_WRITE = 2'd2
`ifdef GL_FB_CLEAR_EN
    ,
    ST_CLEAR = 2'd3
`endif
  } fb_state_e;

endpackage

`default_nettype wire

// File: rtl/gl_fb_writer_if.sv
// ============================================================================
//  Module      : gl_fb_writer_if
//  Description : Fragment FIFO read port plus framebuffer write request port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gl_fb_writer_if #(
  parameter int ADDR_W = 19
) ();

  logic                        empty;
  logic                        rd_en;
  logic [gl_pkg::FRAG_W-1:0]   rd_data;
  logic                        mem_req;
  logic                        mem_ack;
  logic [ADDR_W-1:0]           mem_addr;
  logic [gl_pkg::PIXEL_W-1:0]  mem_wdata;

  modport master (
    input  empty, rd_data, mem_ack,
    output rd_en, mem_req, mem_addr, mem_wdata
  );

  modport slave (
    output empty, rd_data, mem_ack,
    input  rd_en, mem_req, mem_addr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/gl_fb_addr.sv
// ============================================================================
//  Module      : gl_fb_addr
//  Description : Combinational pixel address y*H_RES + x, truncated to ADDR_W.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gl_fb_addr #(
  parameter int H_RES  = 640,
  parameter int ADDR_W = 19
) (
  input  wire logic [gl_pkg::Y_W-1:0] i_y,
  input  wire logic [gl_pkg::X_W-1:0] i_x,
  output logic      [ADDR_W-1:0]      o_addr
);

  assign o_addr = ADDR_W'(i_y) * ADDR_W'(H_RES) + ADDR_W'(i_x);

endmodule

`default_nettype wire

// File: rtl/gl_fb_writer.sv
// ============================================================================
//  Module      : gl_fb_writer
//  Description : Drains rasterizer fragments into 18-bit framebuffer writes,
//                dropping off-screen pixels. GL_FB_CLEAR_EN adds buffer clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gl_fb_writer
  import gl_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = 19,
  parameter int DROP_W = 16
) (
  input  wire logic               clk,
  input  wire logic               rst,
  gl_fb_writer_if.master          fb,
  input  wire logic               clear_start,
  input  wire logic [PIXEL_W-1:0] clear_color,
  output logic                    clear_done,
  output logic                    busy,
  output logic [15:0]             dropped_count
);

  fb_state_e           r_state;
  fb_state_e           w_next;
  logic                w_rd_en;
  logic [ADDR_W-1:0]   r_addr;
  logic [PIXEL_W-1:0]  r_wdata;
  logic [DROP_W-1:0]   r_drop;
  logic [ADDR_W-1:0]   w_pix_addr;
  logic [FRAG_W-1:0]   w_frag;
  logic [Y_W-1:0]      w_y;
  logic [X_W-1:0]      w_x;
  logic [C_W-1:0]      w_r, w_g, w_b;
  logic                w_in_range;
  logic                w_unused_frag;

  assign w_frag = fb.rd_data;
  assign w_y    = w_frag[Y_LSB +: Y_W];
  assign w_x    = w_frag[X_LSB +: X_W];
  assign w_r    = w_frag[R_LSB +: C_W];
  assign w_g    = w_frag[G_LSB +: C_W];
  assign w_b    = w_frag[B_LSB +: C_W];
  assign w_unused_frag = ^{w_frag[95:89], w_frag[79:74], w_frag[63:56],
                           w_frag[49:48], w_frag[41:40], w_frag[33:0]};

  assign w_in_range = (32'(w_x) < 32'(H_RES)) && (32'(w_y) < 32'(V_RES));

  gl_fb_addr #(
    .H_RES  (H_RES),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .i_y    (w_y),
    .i_x    (w_x),
    .o_addr (w_pix_addr)
  );

`ifdef GL_FB_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  logic r_clear_pending;
  logic r_clear_done;

  // Leaving IDLE with a pending clear is the only way into CLEAR
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_clear_pending <= 1'b0;
    else if (r_state == ST_IDLE && r_clear_pending)
      r_clear_pending <= 1'b0;
    else if (clear_start && r_state != ST_CLEAR)
      r_clear_pending <= 1'b1;
  end

  assign clear_done = r_clear_done;
`else
  logic w_unused_clr;
  assign w_unused_clr = ^{clear_start, clear_color};
  assign clear_done   = 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
`ifdef GL_FB_CLEAR_EN
        if (r_clear_pending)
          w_next = ST_CLEAR;
        else
`endif
        if (!fb.empty) begin
          w_rd_en = 1'b1;
          w_next  = ST_LATCH;
        end
      end
      ST_LATCH: w_next = w_in_range ? ST_WRITE : ST_IDLE;
      ST_WRITE: if (fb.mem_ack) w_next = ST_IDLE;
`ifdef GL_FB_CLEAR_EN
      ST_CLEAR: if (fb.mem_ack && r_addr == LAST_ADDR) w_next = ST_IDLE;
`endif
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_drop  <= '0;
`ifdef GL_FB_CLEAR_EN
      r_clear_done <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
`ifdef GL_FB_CLEAR_EN
      r_clear_done <= 1'b0;
`endif
      case (r_state)
        ST_LATCH: begin
          r_addr  <= w_pix_addr;
          r_wdata <= {w_r, w_g, w_b};
          if (!w_in_range && r_drop != '1)
            r_drop <= r_drop + 1'b1;
        end
`ifdef GL_FB_CLEAR_EN
        ST_IDLE: begin
          if (r_clear_pending) begin
            r_addr  <= '0;
            r_wdata <= clear_color;
          end
        end
        ST_CLEAR: begin
          if (fb.mem_ack) begin
            if (r_addr == LAST_ADDR)
              r_clear_done <= 1'b1;
            else
              r_addr <= r_addr + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Reset gates the pop so nothing is lost while the block is held
  assign fb.rd_en     = w_rd_en && !rst;
`ifdef GL_FB_CLEAR_EN
  assign fb.mem_req   = (r_state == ST_WRITE) || (r_state == ST_CLEAR);
`else
  assign fb.mem_req   = (r_state == ST_WRITE);
`endif
  assign fb.mem_addr  = r_addr;
  assign fb.mem_wdata = r_wdata;
  assign busy          = (r_state != ST_IDLE);
  assign dropped_count = 16'(r_drop);

endmodule

`default_nettype wire
